// File: rtl/cska_pkg.sv
// Shared definitions for the multi-word carry-skip sequencer.
//   SLICE_W    : width of one adder slice
//   state_t    : sequencer FSM states
//   signed_ovf : two's-complement overflow from the operand and result sign bits
package cska_pkg;

  localparam int SLICE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Overflow occurs when both operands share a sign and the result sign differs.
  // For subtraction, b_msb must be the sign bit of the inverted B operand.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/carry_skip_32bit.sv
// 32-bit combinational carry-skip adder built from 4-bit ripple blocks.
// Ports:
//   a, b : 32-bit addends
//   cin  : carry into bit 0
//   sum  : 32-bit sum
//   cout : carry out of bit 31
module carry_skip_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int BLK  = 4;
  localparam int NBLK = 32 / BLK;

  // Each block ripples internally. When every bit in a block propagates,
  // the block carry-in is forwarded directly to the next block, so a long
  // propagate run does not have to ripple through every bit.
  always_comb begin : skip_chain
    logic c_blk;
    logic c_rip;
    logic p_blk;
    c_blk = cin;
    c_rip = 1'b0;
    p_blk = 1'b0;
    sum   = '0;
    for (int k = 0; k < NBLK; k++) begin
      c_rip = c_blk;
      p_blk = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        sum[k*BLK+j] = a[k*BLK+j] ^ b[k*BLK+j] ^ c_rip;
        c_rip = (a[k*BLK+j] & b[k*BLK+j]) | ((a[k*BLK+j] ^ b[k*BLK+j]) & c_rip);
        p_blk = p_blk & (a[k*BLK+j] ^ b[k*BLK+j]);
      end
      c_blk = p_blk ? c_blk : c_rip;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/cska_multiword_seq.sv
// Multi-word add/subtract sequencer around one shared 32-bit carry-skip adder.
// One slice is processed per cycle, least significant word first, and the
// carry is chained through a register between slices.
// Ports:
//   clk, rst                : clock and asynchronous active-high reset
//   start_valid/start_ready : operation request handshake (ready only in IDLE)
//   a, b, cin, sub          : operands, carry-in and subtract select, sampled on accept
//   res_valid/res_ready     : result handshake (valid only in DONE)
//   sum, cout, ovf          : registered result, MSW carry out and signed overflow
//   busy                    : high while slices are being processed
module cska_multiword_seq
  import cska_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDX_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int OP_W = SLICE_W * WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [OP_W-1:0]    a_reg;
  logic [OP_W-1:0]    b_reg;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // B is stored already inverted for subtraction, so the adder only ever adds.
  assign slice_a = a_reg[idx*SLICE_W +: SLICE_W];
  assign slice_b = b_reg[idx*SLICE_W +: SLICE_W];

  carry_skip_32bit u_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Sequencer FSM. Handshake and status outputs are registered and change
  // together with the state so they always reflect the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_reg       <= a;
            b_reg       <= sub ? ~b : b;
            carry       <= sub ? 1'b1 : cin;
            idx         <= '0;
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          sum[idx*SLICE_W +: SLICE_W] <= slice_sum;
          carry                       <= slice_cout;
          if (idx == LAST_IDX) begin
            // The final slice carries the sign bits, so it decides cout and ovf.
            cout      <= slice_cout;
            ovf       <= signed_ovf(a_reg[OP_W-1], b_reg[OP_W-1], slice_sum[SLICE_W-1]);
            busy      <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          res_valid   <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cska_multiword_seq.sv
// Self-checking bench for cska_multiword_seq: directed cases plus random
// operations, compared against a plain wide-arithmetic reference model.
module tb_cska_multiword_seq;

  localparam int WORDS = 4;
  localparam int IDX_W = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int errors = 0;
  int checks = 0;

  cska_multiword_seq #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop so a stuck design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain (W+1)-bit arithmetic on the whole operand
  task automatic refModel(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic tsub, output logic [W-1:0] es, output logic ec,
                          output logic eo);
    logic [W-1:0] be;
    logic [W:0]   full;
    be   = tsub ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (ta[W-1] == be[W-1]) && (es[W-1] != ta[W-1]);
  endtask

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Waits for start_ready at a falling edge; false if it never arrives
  task automatic waitReady(output bit ok);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = start_ready;
    if (!ok) checkOutput("ready_timeout", 0, 1);
  endtask

  // Full operation: accept, optional start poke during RUN, latency check,
  // optional backpressure in DONE, then result handoff.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                               input logic tsub, input int hold, input bit poke);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           n;
    bit           ok;
    refModel(ta, tb, tcin, tsub, es, ec, eo);
    waitReady(ok);
    if (!ok) return;
    a = ta; b = tb; cin = tcin; sub = tsub; start_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the in-flight operation must not see them
    start_valid = 1'b0;
    a = randWide(); b = randWide(); cin = 1'($urandom()); sub = 1'($urandom());
    checkOutput("busy_run", busy, 1);
    n = 0;
    while (!res_valid && n < 50) begin
      start_valid = (poke && n == 1);
      if (poke && n == 1) a = ~ta;
      @(posedge clk); #1;
      n++;
    end
    start_valid = 1'b0;
    checkOutput("latency", n, WORDS);
    checkOutput("sum", sum, es);
    checkOutput("cout", cout, ec);
    checkOutput("ovf", ovf, eo);
    checkOutput("start_ready_done", start_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_sum", sum, es);
      checkOutput("hold_cout", cout, ec);
      checkOutput("hold_ovf", ovf, eo);
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_start_ready", start_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("valid_dropped", res_valid, 0);
    checkOutput("start_ready_idle", start_ready, 1);
    checkOutput("sum_retained", sum, es);
  endtask

  initial begin
    logic [W-1:0] va;
    logic [W-1:0] vb;
    bit           ok;
    int           seen;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start_ready", start_ready, 1);

    // All-ones plus carry-in wraps to zero
    applyStimulus({W{1'b1}}, '0, 1'b1, 1'b0, 0, 0);
    // Carry crosses from word 0 into word 1
    applyStimulus(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 0, 0);
    // Subtract with borrow
    applyStimulus(128'h5, 128'h7, 1'b0, 1'b1, 0, 0);
    // Signed overflow on max positive + 1
    applyStimulus({1'b0, {(W-1){1'b1}}}, 128'h1, 1'b0, 1'b0, 0, 0);
    // Backpressure for 3 cycles, and an ignored start during RUN
    applyStimulus(128'h0123_4567_89AB_CDEF_0F0F_0F0F_1234_5678,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0, 3, 0);
    applyStimulus(128'hDEAD_BEEF_0000_0001_CAFE_F00D_8000_0000,
                  128'h0000_0001_FFFF_FFFF_0000_0001_8000_0000, 1'b0, 1'b0, 0, 1);

    // Reset two cycles into RUN discards the operation
    waitReady(ok);
    if (ok) begin
      a = randWide(); b = randWide(); cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checkOutput("midrst_sum", sum, 0);
      checkOutput("midrst_cout", cout, 0);
      checkOutput("midrst_ovf", ovf, 0);
      checkOutput("midrst_res_valid", res_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_start_ready", start_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (res_valid) seen++;
      end
      checkOutput("no_valid_after_rst", seen, 0);
    end
    applyStimulus(128'h1F_0000001F, 128'h0C_0000000C, 1'b0, 1'b0, 0, 0);

    // Random operations with random backpressure
    for (int k = 0; k < 12; k++) begin
      va = randWide();
      vb = randWide();
      applyStimulus(va, vb, 1'($urandom()), 1'($urandom()), int'($urandom_range(0, 2)), 1'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
